set_assoc_cache_ctrl: RTL

//  Parametrised N-way set-associative cache controller; next generation of the way/LRU controller.

---
 rtl/set_assoc_cache_ctrl.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/set_assoc_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module : set_assoc_cache_ctrl
// Brief  : N-way set-associative cache controller, true-LRU replacement,
//          write-back/write-through modes, saturating hit/miss statistics.
// Rev    : 1.0
// ============================================================================
module set_assoc_cache_ctrl #(
    parameter int NUM_WAYS       = 4,
    parameter int NUM_SETS       = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int WRITE_BACK     = 1,
    parameter int STAT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req_valid,
    output logic                     cpu_req_ready,
    input  logic                     cpu_req_write,
    input  logic [ADDRESS_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_req_wdata,
    output logic                     cpu_resp_valid,
    output logic [DATA_WIDTH-1:0]    cpu_resp_rdata,
    output logic                     cpu_resp_hit,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_write,
    output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0]    mem_req_wdata,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [STAT_WIDTH-1:0]    hit_count,
    output logic [STAT_WIDTH-1:0]    miss_count
);
    localparam int c_OFF_W = $clog2(WORDS_PER_LINE);
    localparam int c_IDX_W = $clog2(NUM_SETS);
    localparam int c_TAG_W = ADDRESS_WIDTH - c_IDX_W - c_OFF_W;
    localparam int c_WAY_W = $clog2(NUM_WAYS);
    localparam bit c_WB    = (WRITE_BACK != 0);
    localparam logic [c_OFF_W-1:0]    c_FIRST_BEAT = '0;
    localparam logic [c_OFF_W-1:0]    c_LAST_BEAT  = '1;
    localparam logic [c_WAY_W-1:0]    c_OLDEST     = c_WAY_W'(NUM_WAYS - 1);
    localparam logic [STAT_WIDTH-1:0] c_STAT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_WT_WRITE, S_RESPOND
    } state_t;

    state_t                  r_state;
    logic [c_TAG_W-1:0]      r_tag   [NUM_SETS][NUM_WAYS];
    logic                    r_valid [NUM_SETS][NUM_WAYS];
    logic                    r_dirty [NUM_SETS][NUM_WAYS];
    logic [c_WAY_W-1:0]      r_age   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0]   r_data  [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];

    logic                     r_write;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [c_WAY_W-1:0]       r_way;
    logic [c_OFF_W-1:0]       r_beat;
    logic                     r_wait;
    logic                     r_hit;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_mem_valid;
    logic                     r_mem_write;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0]    r_mem_wdata;
    logic [STAT_WIDTH-1:0]    r_hit_cnt;
    logic [STAT_WIDTH-1:0]    r_miss_cnt;

    logic [c_TAG_W-1:0]    w_tag;
    logic [c_IDX_W-1:0]    w_idx;
    logic [c_OFF_W-1:0]    w_off;
    logic [c_OFF_W-1:0]    w_beat_nxt;
    logic                  w_hit;
    logic [c_WAY_W-1:0]    w_hit_way;
    logic                  w_free_found;
    logic [c_WAY_W-1:0]    w_victim;
    logic                  w_victim_dirty;
    logic                  w_fill_beat;
    logic                  w_lru_en;
    logic [c_WAY_W-1:0]    w_lru_way;
    logic                  w_dwe;
    logic [c_WAY_W-1:0]    w_dway;
    logic [c_OFF_W-1:0]    w_doff;
    logic [DATA_WIDTH-1:0] w_dval;

    assign w_tag          = r_addr[ADDRESS_WIDTH-1 -: c_TAG_W];
    assign w_idx          = r_addr[c_OFF_W +: c_IDX_W];
    assign w_off          = r_addr[c_OFF_W-1:0];
    assign w_beat_nxt     = r_beat + 1'b1;
    assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
    assign w_fill_beat    = (r_state == S_REFILL) && r_wait && mem_rvalid;
    assign w_lru_en       = ((r_state == S_LOOKUP) && w_hit) || (w_fill_beat && (r_beat == c_LAST_BEAT));
    assign w_lru_way      = (r_state == S_LOOKUP) ? w_hit_way : r_way;

    // Victim prefers the lowest-index free way, otherwise the LRU way.
    always_comb begin
        w_hit        = 1'b0;
        w_hit_way    = '0;
        w_free_found = 1'b0;
        w_victim     = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_WAY_W'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_free_found = 1'b1;
                w_victim     = c_WAY_W'(w);
            end
        end
        if (!w_free_found) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (r_age[w_idx][w] == c_OLDEST) w_victim = c_WAY_W'(w);
            end
        end
    end

    // Single data-array write port: write hit, or refill beat with write merge.
    always_comb begin
        w_dwe  = 1'b0;
        w_dway = r_way;
        w_doff = r_beat;
        w_dval = mem_rdata;
        if (!reset && (r_state == S_LOOKUP) && w_hit && r_write) begin
            w_dwe  = 1'b1;
            w_dway = w_hit_way;
            w_doff = w_off;
            w_dval = r_wdata;
        end else if (!reset && w_fill_beat) begin
            w_dwe = 1'b1;
            if (r_write && (r_beat == w_off)) w_dval = r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_dwe) r_data[w_idx][w_dway][w_doff] <= w_dval;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_way       <= '0;
            r_beat      <= '0;
            r_wait      <= 1'b0;
            r_hit       <= 1'b0;
            r_rdata     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_age[s][w]   <= c_WAY_W'(w);
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req_valid) begin
                        r_write <= cpu_req_write;
                        r_addr  <= cpu_req_addr;
                        r_wdata <= cpu_req_wdata;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_hit   <= w_hit;
                    r_rdata <= (w_hit && !r_write) ? r_data[w_idx][w_hit_way][w_off] : '0;
                    r_beat  <= '0;
                    if (w_hit) begin
                        if (r_hit_cnt != c_STAT_MAX) r_hit_cnt <= r_hit_cnt + 1'b1;
                    end else if (r_miss_cnt != c_STAT_MAX) begin
                        r_miss_cnt <= r_miss_cnt + 1'b1;
                    end
                    if (r_write && !c_WB) begin
                        r_mem_valid <= 1'b1;
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                        r_state     <= S_WT_WRITE;
                    end else if (w_hit) begin
                        if (r_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
                        r_way   <= w_hit_way;
                        r_state <= S_RESPOND;
                    end else begin
                        r_way       <= w_victim;
                        r_mem_valid <= 1'b1;
                        if (c_WB && w_victim_dirty) begin
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {r_tag[w_idx][w_victim], w_idx, c_FIRST_BEAT};
                            r_mem_wdata <= r_data[w_idx][w_victim][c_FIRST_BEAT];
                            r_state     <= S_WRITEBACK;
                        end else begin
                            r_mem_write <= 1'b0;
                            r_mem_addr  <= {w_tag, w_idx, c_FIRST_BEAT};
                            r_mem_wdata <= '0;
                            r_state     <= S_REFILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (r_mem_valid && mem_req_ready) begin
                        if (r_beat == c_LAST_BEAT) begin
                            r_beat      <= '0;
                            r_mem_write <= 1'b0;
                            r_mem_addr  <= {w_tag, w_idx, c_FIRST_BEAT};
                            r_mem_wdata <= '0;
                            r_state     <= S_REFILL;
                        end else begin
                            r_beat      <= w_beat_nxt;
                            r_mem_addr  <= {r_tag[w_idx][r_way], w_idx, w_beat_nxt};
                            r_mem_wdata <= r_data[w_idx][r_way][w_beat_nxt];
                        end
                    end
                end
                S_REFILL: begin
                    if (r_mem_valid && mem_req_ready) begin
                        r_mem_valid <= 1'b0;
                        r_wait      <= 1'b1;
                    end else if (w_fill_beat) begin
                        r_wait <= 1'b0;
                        if (!r_write && (r_beat == w_off)) r_rdata <= mem_rdata;
                        if (r_beat == c_LAST_BEAT) begin
                            r_tag[w_idx][r_way]   <= w_tag;
                            r_valid[w_idx][r_way] <= 1'b1;
                            r_dirty[w_idx][r_way] <= r_write;
                            r_state               <= S_RESPOND;
                        end else begin
                            r_beat      <= w_beat_nxt;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= {w_tag, w_idx, w_beat_nxt};
                        end
                    end
                end
                S_WT_WRITE: begin
                    if (r_mem_valid && mem_req_ready) begin
                        r_mem_valid <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= S_RESPOND;
                    end
                end
                S_RESPOND: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase

            // Ages younger than the touched way shift up; touched way becomes MRU.
            if (w_lru_en) begin
                for (int j = 0; j < NUM_WAYS; j++) begin
                    if (r_age[w_idx][j] < r_age[w_idx][w_lru_way])
                        r_age[w_idx][j] <= r_age[w_idx][j] + 1'b1;
                end
                r_age[w_idx][w_lru_way] <= '0;
            end
        end
    end

    assign cpu_req_ready  = (r_state == S_IDLE) && !reset;
    assign cpu_resp_valid = (r_state == S_RESPOND) && !reset;
    assign cpu_resp_hit   = cpu_resp_valid && r_hit;
    assign cpu_resp_rdata = cpu_resp_valid ? r_rdata : '0;
    assign mem_req_valid  = r_mem_valid && !reset;
    assign mem_req_write  = r_mem_write;
    assign mem_req_addr   = r_mem_addr;
    assign mem_req_wdata  = r_mem_wdata;
    assign hit_count      = r_hit_cnt;
    assign miss_count     = r_miss_cnt;

endmodule
`default_nettype wire
